// File: rtl/gates_pipe.sv
// gates_pipe: one-stage bitwise logic unit with valid/ready handshake,
// registered result flags and a saturating completed-transaction counter.
module gates_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Y_ZERO,
  output logic             Y_ONES,
  output logic             Y_PAR,
  output logic [CNT_W-1:0] TXN_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             par;
  } res_t;

  res_t             res;
  res_t             res_d;
  res_t             res_q;
  logic             vld_d;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             hshake;

  // OP decode into the candidate result and its flags
  always_comb begin
    res.y = '0;
    unique case (OP)
      3'b000: res.y = A & B;
      3'b001: res.y = A | B;
      3'b010: res.y = ~(A & B);
      3'b011: res.y = ~(A | B);
      3'b100: res.y = A ^ B;
      3'b101: res.y = ~(A ^ B);
      3'b110: res.y = ~A;
      3'b111: res.y = B;
      default: res.y = '0;
    endcase
    res.zero = ~|res.y;
    res.ones = &res.y;
    res.par  = ^res.y;
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign hshake   = vld_q && out_ready;

  // next state: accept loads, handshake alone drains, counter saturates
  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (accept) begin
      res_d = res;
      vld_d = 1'b1;
    end else if (hshake) begin
      vld_d = 1'b0;
    end
    if (hshake && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // state registers; reset wins over accept and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q.y    <= '0;
      res_q.zero <= 1'b1;
      res_q.ones <= 1'b0;
      res_q.par  <= 1'b0;
      vld_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign Y         = res_q.y;
  assign Y_ZERO    = res_q.zero;
  assign Y_ONES    = res_q.ones;
  assign Y_PAR     = res_q.par;
  assign TXN_CNT   = cnt_q;

endmodule

// File: tb/tb_gates_pipe.sv
// tb_gates_pipe: directed self-checking bench for gates_pipe
// (default, CNT_W=2 and WIDTH=1 instances sharing one stimulus).
module tb_gates_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  A;
  logic [3:0]  B;
  logic [2:0]  OP;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  Y;
  logic        y_zero;
  logic        y_ones;
  logic        y_par;
  logic [15:0] txn_cnt;

  logic        c2_in_ready;
  logic        c2_out_valid;
  logic [3:0]  c2_y;
  logic        c2_zero;
  logic        c2_ones;
  logic        c2_par;
  logic [1:0]  c2_cnt;

  logic        w1_in_ready;
  logic        w1_out_valid;
  logic [0:0]  w1_y;
  logic        w1_zero;
  logic        w1_ones;
  logic        w1_par;
  logic [15:0] w1_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_y [8];

  always #5 clk = ~clk;

  gates_pipe #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Y_ZERO(y_zero), .Y_ONES(y_ones),
    .Y_PAR(y_par), .TXN_CNT(txn_cnt)
  );

  gates_pipe #(.WIDTH(4), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(c2_in_ready),
    .A(A), .B(B), .OP(OP),
    .out_valid(c2_out_valid), .out_ready(out_ready),
    .Y(c2_y), .Y_ZERO(c2_zero), .Y_ONES(c2_ones),
    .Y_PAR(c2_par), .TXN_CNT(c2_cnt)
  );

  gates_pipe #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w1_in_ready),
    .A(A[0:0]), .B(B[0:0]), .OP(OP),
    .out_valid(w1_out_valid), .out_ready(out_ready),
    .Y(w1_y), .Y_ZERO(w1_zero), .Y_ONES(w1_ones),
    .Y_PAR(w1_par), .TXN_CNT(w1_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_y[0] = 4'b1000; exp_y[1] = 4'b1110;
    exp_y[2] = 4'b0111; exp_y[3] = 4'b0001;
    exp_y[4] = 4'b0110; exp_y[5] = 4'b1001;
    exp_y[6] = 4'b0011; exp_y[7] = 4'b1010;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 4'h0; B = 4'h0; OP = 3'd0;
    tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_y", Y, 0);
    chk("rst_zero", y_zero, 1);
    chk("rst_ones", y_ones, 0);
    chk("rst_par", y_par, 0);
    chk("rst_cnt", txn_cnt, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", in_ready, 1);

    // all eight ops back-to-back
    A = 4'b1100; B = 4'b1010;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      OP = 3'(op);
      tick();
      chk($sformatf("op%0d_y", op), Y, exp_y[op]);
      chk($sformatf("op%0d_vld", op), out_valid, 1);
    end
    chk("ops_cnt7", txn_cnt, 7);
    in_valid = 1'b0;
    tick();
    chk("ops_cnt8", txn_cnt, 8);
    chk("ops_drain_vld", out_valid, 0);
    chk("ops_retain_y", Y, 4'b1010);

    // flags
    in_valid = 1'b1;
    OP = 3'b100; A = 4'b0101; B = 4'b0101;
    tick();
    chk("xor_y", Y, 4'b0000);
    chk("xor_zero", y_zero, 1);
    chk("xor_ones", y_ones, 0);
    chk("xor_par", y_par, 0);
    OP = 3'b101;
    tick();
    chk("xnor_y", Y, 4'b1111);
    chk("xnor_ones", y_ones, 1);
    chk("xnor_zero", y_zero, 0);
    chk("xnor_par", y_par, 0);
    chk("w1_y", w1_y, 1);
    chk("w1_ones", w1_ones, 1);
    chk("w1_zero", w1_zero, 0);
    chk("w1_par", w1_par, 1);
    in_valid = 1'b0;
    tick();
    chk("flags_cnt", txn_cnt, 10);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    OP = 3'b001; A = 4'b0011; B = 4'b0101;
    tick();
    chk("bp_y", Y, 4'b0111);
    chk("bp_vld", out_valid, 1);
    chk("bp_rdy", in_ready, 0);
    OP = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_y", i), Y, 4'b0111);
      chk($sformatf("bp_hold%0d_rdy", i), in_ready, 0);
    end
    chk("bp_hold_cnt", txn_cnt, 10);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", in_ready, 1);
    tick();
    chk("bp_second_y", Y, 4'b0001);
    chk("bp_second_vld", out_valid, 1);
    chk("bp_second_cnt", txn_cnt, 11);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_cnt", txn_cnt, 12);

    // reset while stalled
    out_ready = 1'b0; in_valid = 1'b1;
    OP = 3'b001; A = 4'b0011; B = 4'b0101;
    tick();
    chk("rs_pre_vld", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    chk("rs_vld", out_valid, 0);
    chk("rs_y", Y, 0);
    chk("rs_zero", y_zero, 1);
    chk("rs_cnt", txn_cnt, 0);
    chk("rs_rdy", in_ready, 1);
    chk("rs_c2_cnt", c2_cnt, 0);
    rst = 1'b0;

    // saturation on the CNT_W=2 instance
    in_valid = 1'b1; out_ready = 1'b1;
    OP = 3'b000; A = 4'hF; B = 4'h3;
    tick();
    chk("sat_c2_cnt0", c2_cnt, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("sat_c2_cnt%0d", i), c2_cnt,
          (i < 3) ? i : 3);
    end
    in_valid = 1'b0;
    tick();
    chk("sat_c2_cnt5", c2_cnt, 3);
    chk("sat_main_cnt", txn_cnt, 5);

    // sustained stream of NOR of zeros
    rst = 1'b1;
    tick();
    chk("st_rst_cnt", txn_cnt, 0);
    rst = 1'b0;
    A = 4'h0; B = 4'h0; OP = 3'b011;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("st%0d_y", i), Y, 4'b1111);
      chk($sformatf("st%0d_vld", i), out_valid, 1);
    end
    chk("st_cnt", txn_cnt, 3);

    // inputs ignored without accept
    in_valid = 1'b0;
    tick();
    A = 4'h5; OP = 3'b000;
    tick();
    chk("ign_y", Y, 4'b1111);
    chk("ign_vld", out_valid, 0);
    chk("ign_cnt", txn_cnt, 4);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/gates_pipe.md
GATES_PIPE -- requirements
Module: gates_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: operand and result width in bits, legal range 1..32.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the transaction counter, legal range 2..32.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  A/B/OP hold a valid request.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL provide port A  input  WIDTH  first operand.
REQ-008 SHALL provide port B  input  WIDTH  second operand.
REQ-009 SHALL provide port OP  input  3  operation select.
REQ-010 SHALL provide port out_valid  output  1  Y and flags hold a valid result.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL provide port Y  output  WIDTH  registered bitwise result.
REQ-013 SHALL provide port Y_ZERO  output  1  registered: Y is all zeros.
REQ-014 SHALL provide port Y_ONES  output  1  registered: Y is all ones.
REQ-015 SHALL provide port Y_PAR  output  1  registered: XOR-reduction of Y.
REQ-016 SHALL provide port TXN_CNT  output  CNT_W  count of completed output handshakes.

Function
REQ-017 SHALL decode OP bitwise over WIDTH: 000 A&B, 001 A|B, 010 ~(A&B), 011 ~(A|B), 100 A^B, 101 ~(A^B), 110 ~A, 111 B.
REQ-018 SHALL drive in_ready combinationally as (!out_valid || out_ready); no combinational path from in_valid to in_ready.
REQ-019 SHALL accept a request on any edge where in_valid && in_ready.
REQ-020 SHALL, on accept, load Y, Y_ZERO, Y_ONES, Y_PAR from the current A/B/OP and set out_valid=1 at that edge: latency exactly 1 cycle.
REQ-021 SHALL complete an output handshake on any edge where out_valid && out_ready.
REQ-022 SHALL clear out_valid on a handshake edge with no simultaneous accept.
REQ-023 SHALL, on simultaneous handshake and accept, load the new result and keep out_valid=1, sustaining one result per cycle.
REQ-024 SHALL hold Y and all flags stable while out_valid=1 and out_ready=0, regardless of A/B/OP/in_valid.
REQ-025 SHALL retain the last Y and flags after out_valid drops, until the next accept or reset.
REQ-026 SHALL ignore A/B/OP when no accept occurs.
REQ-027 SHALL increment TXN_CNT by 1 on every output handshake edge, saturating at 2^CNT_W-1 with no wrap.
REQ-028 SHALL, for WIDTH=1, assert Y_ZERO and Y_ONES mutually exclusively, with Y_PAR equal to Y.

Reset
REQ-029 SHALL, on any edge with rst=1, set out_valid=0, Y=0, Y_ZERO=1, Y_ONES=0, Y_PAR=0, TXN_CNT=0.
REQ-030 SHALL give rst priority over accept and handshake on the same edge: a pending result is discarded and not counted.
REQ-031 SHALL drive in_ready=1 during and immediately after reset, since out_valid=0.

Verification
REQ-032 SHALL verify (WIDTH=4) A=1100, B=1010, OP=000..111 back-to-back with out_ready=1 -> Y=1000,1110,0111,0001,0110,1001,0011,1010 on consecutive cycles, each one cycle after its accept, TXN_CNT=8.
REQ-033 SHALL verify OP=100, A=B=0101 -> Y=0000, Y_ZERO=1, Y_PAR=0; then OP=101 -> Y=1111, Y_ONES=1, Y_PAR=0.
REQ-034 SHALL verify out_ready=0 with two requests offered (OP=001 then OP=000, A=0011, B=0101): first accepted, Y=0111; in_ready=0; Y held 5 cycles; out_ready=1 -> second accepted that edge, Y=0001 next cycle.
REQ-035 SHALL verify CNT_W=2 with 5 completed handshakes -> TXN_CNT=1,2,3,3,3.
REQ-036 SHALL verify rst asserted one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, Y=0000, Y_ZERO=1, TXN_CNT=0, in_ready=1.
REQ-037 SHALL verify A=B=0, OP=011, with in_valid and out_ready high for 4 cycles -> Y=1111 held, out_valid=1 continuously, TXN_CNT=3 after the fourth edge.
